// File: rtl/i2c_target_regfile_if.sv
// Pin and local-port bundle of i2c_target_regfile: I2C pad signals, CPU-side register port and commit/busy status.
// The slave modport is the target itself; the master modport is whatever drives the pads and the CPU port.
interface i2c_target_regfile_if #(
    parameter int ADDR_W = 4
);
    logic              io_i2c_scl_read;
    logic              io_i2c_sda_read;
    logic              io_i2c_sda_write;
    logic              io_regWrite;
    logic [ADDR_W-1:0] io_regAddr;
    logic [7:0]        io_regWdata;
    logic [7:0]        io_regRdata;
    logic              io_busWrite;
    logic [ADDR_W-1:0] io_busAddr;
    logic [7:0]        io_busData;
    logic              io_busy;

    modport slave (
        input  io_i2c_scl_read, io_i2c_sda_read, io_regWrite, io_regAddr, io_regWdata,
        output io_i2c_sda_write, io_regRdata, io_busWrite, io_busAddr, io_busData, io_busy
    );

    modport master (
        output io_i2c_scl_read, io_i2c_sda_read, io_regWrite, io_regAddr, io_regWdata,
        input  io_i2c_sda_write, io_regRdata, io_busWrite, io_busAddr, io_busData, io_busy
    );
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target exposing REG_COUNT 8-bit registers (pointer byte, then auto-incrementing data) plus a local CPU port.
// Optional build macro I2C_TARGET_FILTER_EN adds a 3-sample majority glitch filter on SCL/SDA after the synchronizers.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int          REG_COUNT  = 16,
    parameter int          ADDR_W     = 4
) (
    input logic                  io_mainClk,
    input logic                  io_asyncReset,
    i2c_target_regfile_if.slave  bus
);
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    // Pad synchronizers; idle bus level is high so reset to 1 to avoid a phantom START.
    logic [1:0] scl_sync_reg;
    logic [1:0] sda_sync_reg;
    logic       scl_s;
    logic       sda_s;
    logic       scl_prev_reg;
    logic       sda_prev_reg;

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], bus.io_i2c_scl_read};
            sda_sync_reg <= {sda_sync_reg[0], bus.io_i2c_sda_read};
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    logic [1:0] scl_hist_reg;
    logic [1:0] sda_hist_reg;

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            scl_hist_reg <= 2'b11;
            sda_hist_reg <= 2'b11;
        end else begin
            scl_hist_reg <= {scl_hist_reg[0], scl_sync_reg[1]};
            sda_hist_reg <= {sda_hist_reg[0], sda_sync_reg[1]};
        end
    end

    // Majority of the newest three samples: a single-sample excursion never wins.
    assign scl_s = (scl_sync_reg[1] & scl_hist_reg[0]) | (scl_sync_reg[1] & scl_hist_reg[1]) |
                   (scl_hist_reg[0] & scl_hist_reg[1]);
    assign sda_s = (sda_sync_reg[1] & sda_hist_reg[0]) | (sda_sync_reg[1] & sda_hist_reg[1]) |
                   (sda_hist_reg[0] & sda_hist_reg[1]);
`else
    assign scl_s = scl_sync_reg[1];
    assign sda_s = sda_sync_reg[1];
`endif

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  =  scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s &  scl_prev_reg;
    assign start_det =  scl_s &  scl_prev_reg &  sda_prev_reg & ~sda_s;
    assign stop_det  =  scl_s &  scl_prev_reg & ~sda_prev_reg &  sda_s;

    // FSM and datapath state
    state_t            state_reg,     state_next;
    logic [3:0]        bit_cnt_reg,   bit_cnt_next;
    logic [7:0]        shift_reg,     shift_next;
    logic [ADDR_W-1:0] pointer_reg,   pointer_next;
    logic              sda_out_reg,   sda_out_next;
    logic              rw_reg,        rw_next;
    logic              ack_seen_reg,  ack_seen_next;
    logic              busy_reg,      busy_next;
    logic              bus_write_reg, bus_write_next;
    logic [ADDR_W-1:0] bus_addr_reg,  bus_addr_next;
    logic [7:0]        bus_data_reg,  bus_data_next;
    logic              reg_wr_en;

    logic [7:0] regs_q [REG_COUNT];

    // Register file: the local port has priority over an I2C commit to the same index.
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            logic [7:0] data_reg;

            always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
                if (io_asyncReset) begin
                    data_reg <= 8'h00;
                end else if (bus.io_regWrite && (bus.io_regAddr == ADDR_W'(gi))) begin
                    data_reg <= bus.io_regWdata;
                end else if (reg_wr_en && (pointer_reg == ADDR_W'(gi))) begin
                    data_reg <= shift_reg;
                end
            end

            assign regs_q[gi] = data_reg;
        end
    endgenerate

    assign bus.io_regRdata = regs_q[bus.io_regAddr];

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 8'h00;
            pointer_reg   <= '0;
            sda_out_reg   <= 1'b1;
            rw_reg        <= 1'b0;
            ack_seen_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            bus_write_reg <= 1'b0;
            bus_addr_reg  <= '0;
            bus_data_reg  <= 8'h00;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            pointer_reg   <= pointer_next;
            sda_out_reg   <= sda_out_next;
            rw_reg        <= rw_next;
            ack_seen_reg  <= ack_seen_next;
            busy_reg      <= busy_next;
            bus_write_reg <= bus_write_next;
            bus_addr_reg  <= bus_addr_next;
            bus_data_reg  <= bus_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        pointer_next   = pointer_reg;
        sda_out_next   = sda_out_reg;
        rw_next        = rw_reg;
        ack_seen_next  = ack_seen_reg;
        busy_next      = busy_reg;
        bus_write_next = 1'b0;
        bus_addr_next  = bus_addr_reg;
        bus_data_next  = bus_data_reg;
        reg_wr_en      = 1'b0;

        if (stop_det) begin
            state_next   = ST_IDLE;
            sda_out_next = 1'b1;
            busy_next    = 1'b0;
        end else if (start_det) begin
            state_next    = ST_ADDR;
            bit_cnt_next  = 4'd0;
            sda_out_next  = 1'b1;
            busy_next     = 1'b0;
            ack_seen_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && (bit_cnt_reg != 4'd8)) begin
                        shift_next   = {shift_reg[6:0], sda_s};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && (bit_cnt_reg == 4'd8)) begin
                        bit_cnt_next = 4'd0;
                        if (state_reg == ST_ADDR) begin
                            if (shift_reg[7:1] == TARGET_ADDR) begin
                                state_next   = ST_ADDR_ACK;
                                sda_out_next = 1'b0;
                                busy_next    = 1'b1;
                                rw_next      = shift_reg[0];
                            end else begin
                                state_next = ST_IGNORE;
                            end
                        end else if (state_reg == ST_PTR) begin
                            pointer_next = shift_reg[ADDR_W-1:0];
                            state_next   = ST_PTR_ACK;
                            sda_out_next = 1'b0;
                        end else begin
                            reg_wr_en      = 1'b1;
                            bus_write_next = 1'b1;
                            bus_addr_next  = pointer_reg;
                            bus_data_next  = shift_reg;
                            pointer_next   = pointer_reg + ADDR_W'(1);
                            state_next     = ST_WDATA_ACK;
                            sda_out_next   = 1'b0;
                        end
                    end
                end

                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if ((state_reg == ST_ADDR_ACK) && rw_reg) begin
                            // The byte is frozen here; later local writes do not disturb it.
                            shift_next   = regs_q[pointer_reg];
                            sda_out_next = regs_q[pointer_reg][7];
                            bit_cnt_next = 4'd1;
                            state_next   = ST_RDATA;
                        end else begin
                            sda_out_next = 1'b1;
                            bit_cnt_next = 4'd0;
                            state_next   = (state_reg == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_out_next  = 1'b1;
                            ack_seen_next = 1'b0;
                            state_next    = ST_RDATA_ACK;
                        end else begin
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_out_next = shift_reg[6];
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_next = ST_IGNORE;
                        end else begin
                            ack_seen_next = 1'b1;
                            pointer_next  = pointer_reg + ADDR_W'(1);
                        end
                    end else if (scl_fall && ack_seen_reg) begin
                        shift_next    = regs_q[pointer_reg];
                        sda_out_next  = regs_q[pointer_reg][7];
                        bit_cnt_next  = 4'd1;
                        ack_seen_next = 1'b0;
                        state_next    = ST_RDATA;
                    end
                end

                default: begin
                    sda_out_next = 1'b1;
                end
            endcase
        end
    end

    assign bus.io_i2c_sda_write = sda_out_reg;
    assign bus.io_busWrite      = bus_write_reg;
    assign bus.io_busAddr       = bus_addr_reg;
    assign bus.io_busData       = bus_data_reg;
    assign bus.io_busy          = busy_reg;
endmodule
